// File: rtl/decode.sv
// Purpose: RV32I instruction-decode stage; decodes instrD, reads the 32x32 register file and latches the result into ID/EX.
// Latency: rs1D/rs2D are combinational; every *E output is valid one rising edge after instrD is presented.
// Backpressure: none inside the stage; stalls hold F/D upstream and execute gets a bubble through flushE.
//
// Ports:
//   clk, rst                    - clock, synchronous active-low reset
//   instrD, PCD, PCp4D          - IF/ID register contents
//   reg_writeW, rdW, resultW    - writeback port into the register file
//   flushE                      - loads a bubble into ID/EX
//   rs1D, rs2D                  - source register numbers for the hazard unit
//   *E                          - ID/EX register outputs feeding execute
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCp4D,
    input  logic        reg_writeW,
    input  logic [4:0]  rdW,
    input  logic [31:0] resultW,
    input  logic        flushE,
    output logic [4:0]  rs1D,
    output logic [4:0]  rs2D,
    output logic        reg_writeE,
    output logic        mem_writeE,
    output logic        jumpE,
    output logic        branchE,
    output logic        alu_srcE,
    output logic [1:0]  result_srcE,
    output logic [2:0]  alu_controlE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] imm_extE,
    output logic [31:0] PCE,
    output logic [31:0] PCp4E,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE,
    output logic        illegalE
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rdD;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign funct7 = instrD[31:25];
    assign rdD    = instrD[11:7];
    assign rs1D   = instrD[19:15];
    assign rs2D   = instrD[24:20];

    // Immediate candidates, all sign-extended from instr[31]
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
    assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign imm_b = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
    assign imm_j = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};

    logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, illegal_d;
    logic [1:0]  result_src_d;
    logic [2:0]  alu_control_d;
    logic [31:0] imm_d;

    // Immediate follows the opcode class even when funct fields make the
    // instruction illegal; control is only asserted for fully legal encodings.
    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        result_src_d  = 2'b00;
        alu_control_d = ALU_ADD;
        illegal_d     = 1'b0;
        imm_d         = 32'h0;
        case (opcode)
            OP_LOAD: begin
                imm_d = imm_i;
                if (funct3 == 3'b010) begin
                    reg_write_d  = 1'b1;
                    alu_src_d    = 1'b1;
                    result_src_d = 2'b01;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_STORE: begin
                imm_d = imm_s;
                if (funct3 == 3'b010) begin
                    mem_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_control_d = ALU_ADD;
                    10'b0100000_000: alu_control_d = ALU_SUB;
                    10'b0000000_111: alu_control_d = ALU_AND;
                    10'b0000000_110: alu_control_d = ALU_OR;
                    10'b0000000_010: alu_control_d = ALU_SLT;
                    default: begin
                        reg_write_d = 1'b0;
                        illegal_d   = 1'b1;
                    end
                endcase
            end
            OP_IALU: begin
                imm_d       = imm_i;
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                // funct7 is part of the immediate here, so addi never becomes sub
                case (funct3)
                    3'b000: alu_control_d = ALU_ADD;
                    3'b111: alu_control_d = ALU_AND;
                    3'b110: alu_control_d = ALU_OR;
                    3'b010: alu_control_d = ALU_SLT;
                    default: begin
                        reg_write_d = 1'b0;
                        alu_src_d   = 1'b0;
                        illegal_d   = 1'b1;
                    end
                endcase
            end
            OP_BRANCH: begin
                imm_d = imm_b;
                if (funct3 == 3'b000) begin
                    branch_d      = 1'b1;
                    alu_control_d = ALU_SUB;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_JAL: begin
                imm_d        = imm_j;
                jump_d       = 1'b1;
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
            end
            default: begin
                // all-zero word is the fetch bubble, not an illegal instruction
                illegal_d = (instrD != 32'h0);
            end
        endcase
    end

    // Register file; entry 0 is cleared by reset and never written
    logic [31:0] rf [32];
    logic        wb_en;
    logic [31:0] rd1_d, rd2_d;

    assign wb_en = reg_writeW && (rdW != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else if (wb_en) begin
            rf[rdW] <= resultW;
        end
    end

    // Write-through so a same-cycle writeback reaches ID/EX without a stall
    always_comb begin
        rd1_d = 32'h0;
        rd2_d = 32'h0;
        if (rs1D != 5'd0) begin
            rd1_d = (wb_en && rdW == rs1D) ? resultW : rf[rs1D];
        end
        if (rs2D != 5'd0) begin
            rd2_d = (wb_en && rdW == rs2D) ? resultW : rf[rs2D];
        end
    end

    // ID/EX register; reset and flush both load an all-zero bubble
    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            reg_writeE   <= 1'b0;
            mem_writeE   <= 1'b0;
            jumpE        <= 1'b0;
            branchE      <= 1'b0;
            alu_srcE     <= 1'b0;
            result_srcE  <= 2'b00;
            alu_controlE <= 3'b000;
            rd1E         <= 32'h0;
            rd2E         <= 32'h0;
            imm_extE     <= 32'h0;
            PCE          <= 32'h0;
            PCp4E        <= 32'h0;
            rs1E         <= 5'd0;
            rs2E         <= 5'd0;
            rdE          <= 5'd0;
            illegalE     <= 1'b0;
        end else begin
            reg_writeE   <= reg_write_d;
            mem_writeE   <= mem_write_d;
            jumpE        <= jump_d;
            branchE      <= branch_d;
            alu_srcE     <= alu_src_d;
            result_srcE  <= result_src_d;
            alu_controlE <= alu_control_d;
            rd1E         <= rd1_d;
            rd2E         <= rd2_d;
            imm_extE     <= imm_d;
            PCE          <= PCD;
            PCp4E        <= PCp4D;
            rs1E         <= rs1D;
            rs2E         <= rs2D;
            rdE          <= rdD;
            illegalE     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Purpose: self-checking bench for decode; directed cases plus randomized traffic against a mnemonic-level model.
// Latency: model expectations are formed at each rising edge and compared on the following falling edge.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD, PCD, PCp4D;
    logic        reg_writeW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic        flushE;
    logic [4:0]  rs1D, rs2D;
    logic        reg_writeE, mem_writeE, jumpE, branchE, alu_srcE;
    logic [1:0]  result_srcE;
    logic [2:0]  alu_controlE;
    logic [31:0] rd1E, rd2E, imm_extE, PCE, PCp4E;
    logic [4:0]  rs1E, rs2E, rdE;
    logic        illegalE;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCp4D(PCp4D),
        .reg_writeW(reg_writeW), .rdW(rdW), .resultW(resultW), .flushE(flushE),
        .rs1D(rs1D), .rs2D(rs2D),
        .reg_writeE(reg_writeE), .mem_writeE(mem_writeE), .jumpE(jumpE),
        .branchE(branchE), .alu_srcE(alu_srcE), .result_srcE(result_srcE),
        .alu_controlE(alu_controlE), .rd1E(rd1E), .rd2E(rd2E), .imm_extE(imm_extE),
        .PCE(PCE), .PCp4E(PCp4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .illegalE(illegalE)
    );

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } e_t;

    typedef enum {K_BUBBLE, K_LW, K_SW, K_ADD, K_SUB, K_AND, K_OR, K_SLT,
                  K_ADDI, K_ANDI, K_ORI, K_SLTI, K_BEQ, K_JAL, K_ILL} kind_t;

    e_t dut_e;
    assign dut_e = {reg_writeE, mem_writeE, jumpE, branchE, alu_srcE, result_srcE,
                    alu_controlE, rd1E, rd2E, imm_extE, PCE, PCp4E, rs1E, rs2E, rdE, illegalE};

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [31:0] mrf [32];
    e_t          exp_e;
    logic        exp_valid = 1'b0;

    function automatic kind_t classify(logic [31:0] i);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        if (i == 32'h0) return K_BUBBLE;
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
        if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
        if (op == 7'h6f) return K_JAL;
        if (op == 7'h13) begin
            if (f3 == 3'd0) return K_ADDI;
            if (f3 == 3'd7) return K_ANDI;
            if (f3 == 3'd6) return K_ORI;
            if (f3 == 3'd2) return K_SLTI;
        end
        if (op == 7'h33 && f7 == 7'h00) begin
            if (f3 == 3'd0) return K_ADD;
            if (f3 == 3'd7) return K_AND;
            if (f3 == 3'd6) return K_OR;
            if (f3 == 3'd2) return K_SLT;
        end
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return K_SUB;
        return K_ILL;
    endfunction

    function automatic logic [31:0] readreg(logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (reg_writeW && rdW == r) return resultW;
        return mrf[r];
    endfunction

    function automatic e_t model_e(logic [31:0] i);
        e_t    e = '0;
        kind_t k = classify(i);
        e.pc   = PCD;
        e.pcp4 = PCp4D;
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.rd   = i[11:7];
        e.rd1  = readreg(i[19:15]);
        e.rd2  = readreg(i[24:20]);
        case (i[6:0])
            7'h03, 7'h13: e.imm = {{20{i[31]}}, i[31:20]};
            7'h23:        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:        e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h6f:        e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default:      e.imm = 32'h0;
        endcase
        case (k)
            K_LW:   begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; end
            K_SW:   begin e.mem_write = 1; e.alu_src = 1; end
            K_ADD:  e.reg_write = 1;
            K_SUB:  begin e.reg_write = 1; e.alu_control = 3'b001; end
            K_AND:  begin e.reg_write = 1; e.alu_control = 3'b010; end
            K_OR:   begin e.reg_write = 1; e.alu_control = 3'b011; end
            K_SLT:  begin e.reg_write = 1; e.alu_control = 3'b101; end
            K_ADDI: begin e.reg_write = 1; e.alu_src = 1; end
            K_ANDI: begin e.reg_write = 1; e.alu_src = 1; e.alu_control = 3'b010; end
            K_ORI:  begin e.reg_write = 1; e.alu_src = 1; e.alu_control = 3'b011; end
            K_SLTI: begin e.reg_write = 1; e.alu_src = 1; e.alu_control = 3'b101; end
            K_BEQ:  begin e.branch = 1; e.alu_control = 3'b001; end
            K_JAL:  begin e.jump = 1; e.reg_write = 1; e.result_src = 2'b10; end
            default: ;
        endcase
        e.illegal = (k == K_ILL);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            exp_e = '0;
            for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        end else begin
            exp_e = flushE ? '0 : model_e(instrD);
            if (reg_writeW && rdW != 5'd0) mrf[rdW] = resultW;
        end
        exp_valid = 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_valid) begin
            total++;
            if (dut_e !== exp_e) begin
                bad++;
                $display("FAIL e_outputs t=%0t got=%h want=%h", $time, dut_e, exp_e);
            end
            total++;
            if ({rs1D, rs2D} !== {instrD[19:15], instrD[24:20]}) begin
                bad++;
                $display("FAIL rs_comb t=%0t got=%h,%h want=%h,%h", $time, rs1D, rs2D,
                         instrD[19:15], instrD[24:20]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [31:0] ins, input logic r, input logic fl,
                        input logic we, input logic [4:0] rdw, input logic [31:0] res);
        #2;
        instrD     = ins;
        rst        = r;
        flushE     = fl;
        reg_writeW = we;
        rdW        = rdw;
        resultW    = res;
        PCD        = $urandom & 32'hFFFF_FFFC;
        PCp4D      = PCD + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  r1  = 5'($urandom_range(0, 7));
        logic [4:0]  r2  = 5'($urandom_range(0, 7));
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [11:0] im  = 12'($urandom);
        logic [2:0]  f3  = 3'($urandom);
        logic [2:0]  f3s;
        case ($urandom_range(0, 3))
            0: f3s = 3'd0;
            1: f3s = 3'd7;
            2: f3s = 3'd6;
            default: f3s = 3'd2;
        endcase
        case ($urandom_range(0, 11))
            0:  return {im, r1, 3'b010, rd, 7'h03};
            1:  return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
            2:  return {7'h00, r2, r1, f3s, rd, 7'h33};
            3:  return {7'h20, r2, r1, 3'b000, rd, 7'h33};
            4:  return {im, r1, f3, rd, 7'h13};
            5:  return {im[11:5], r2, r1, ($urandom_range(0, 3) == 0) ? f3 : 3'b000, im[4:0], 7'h63};
            6:  return {im, 8'($urandom), rd, 7'h6f};
            7:  return $urandom;
            8:  return 32'h0;
            9:  return {7'($urandom), r2, r1, f3, rd, 7'h33};
            10: return {7'($urandom), r2, r1, f3, rd, 7'($urandom)};
            default: return {im, r1, f3s, rd, 7'h13};
        endcase
    endfunction

    initial begin
        rst = 1'b0; instrD = 32'h0; PCD = 32'h0; PCp4D = 32'h4;
        reg_writeW = 1'b0; rdW = 5'd0; resultW = 32'h0; flushE = 1'b0;

        // reset with a live instruction and a writeback that must be discarded
        step(32'h00500093, 1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA5555);
        step(32'h00500093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("reset_any_e", {31'b0, |dut_e}, 32'h0);

        for (int i = 1; i < 32; i++) begin
            logic [4:0] r = 5'(i);
            step({7'h00, r, r, 3'b000, 5'd0, 7'h33}, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            chk("reset_reg_read", rd1E | rd2E, 32'h0);
        end

        // addi x1,x0,5
        step(32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("addi_ctrl", {26'b0, reg_writeE, alu_srcE, alu_controlE, illegalE}, {26'b0, 6'b110000});
        chk("addi_imm", imm_extE, 32'd5);
        chk("addi_rd", {27'b0, rdE}, 32'd1);

        // add x2,x1,x1 while x1=5 is being written back
        step(32'h00108133, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
        chk("bypass_rd1", rd1E, 32'd5);
        chk("bypass_rd2", rd2E, 32'd5);
        chk("add_alu", {29'b0, alu_controlE}, 32'd0);

        step(32'hFE21AE23, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("sw_imm", imm_extE, 32'hFFFFFFFC);
        chk("sw_memw", {31'b0, mem_writeE}, 32'd1);

        step(32'hFE000CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("beq_imm", imm_extE, 32'hFFFFFFF8);
        chk("beq_ctrl", {28'b0, branchE, alu_controlE}, {28'b0, 4'b1001});

        step(32'h001000EF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("jal_imm", imm_extE, 32'h00000800);
        chk("jal_ctrl", {29'b0, jumpE, result_srcE}, {29'b0, 3'b110});

        // x0 stays zero both after and during a writeback to it
        step(32'h00000013, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000DEAD);
        step(32'h000001B3, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000DEAD);
        chk("x0_read", rd1E | rd2E, 32'h0);

        // flush of lw x5,0(x1) with a concurrent writeback to x7
        step(32'h0000A283, 1'b1, 1'b1, 1'b1, 5'd7, 32'h12345678);
        chk("flush_any_e", {31'b0, |dut_e}, 32'h0);
        step({7'h00, 5'd7, 5'd7, 3'b000, 5'd0, 7'h33}, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_wb_kept", rd1E, 32'h12345678);

        step(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("illegal_flag", {31'b0, illegalE}, 32'd1);
        chk("illegal_ctrl", {22'b0, reg_writeE, mem_writeE, jumpE, branchE, alu_srcE,
                             result_srcE, alu_controlE}, 32'h0);

        step(32'h00000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("bubble_flag", {31'b0, illegalE}, 32'd0);
        chk("bubble_ctrl", {22'b0, reg_writeE, mem_writeE, jumpE, branchE, alu_srcE,
                            result_srcE, alu_controlE}, 32'h0);

        // randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ins = rand_instr();
            logic        we  = 1'($urandom);
            logic [4:0]  rdw = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom_range(0, 7));
            step(ins, ($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
                 we, rdw, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the five-stage RV32I pipeline, directly downstream of fetch. Consumes the IF/ID outputs (instrD, PCD, PCp4D), decodes control, generates the immediate, reads the 32×32 register file (written back from the writeback stage), and holds the result in the ID/EX pipeline register feeding execute. Exposes source and destination register numbers for the hazard unit.

## Interface
- No parameters. Data width is fixed at 32 bits, and there are 32 registers.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — reset, synchronous, active-low.
- instrD  in  32  — instruction from the IF/ID register.
- PCD, PCp4D  in  32 each  — PC and PC+4 from the IF/ID register.
- reg_writeW  in  1  — writeback enable.
- rdW  in  5  — writeback destination register.
- resultW  in  32  — writeback data.
- flushE  in  1  — from the hazard unit; loads a bubble into ID/EX.
- rs1D, rs2D  out  5 each  — combinational instrD[19:15] and instrD[24:20], for the hazard unit.
- reg_writeE, mem_writeE, jumpE, branchE, alu_srcE  out  1 each  — registered control.
- result_srcE  out  2  — registered: 00 ALU, 01 memory, 10 PC+4.
- alu_controlE  out  3  — registered: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- rd1E, rd2E, imm_extE, PCE, PCp4E  out  32 each  — registered data.
- rs1E, rs2E, rdE  out  5 each  — registered register numbers.
- illegalE  out  1  — registered; the instruction in E is unsupported.

## Operation
- Supported instructions:
  - lw (0000011)
  - sw (0100011)
  - R-type (0110011): add, sub, and, or, slt
  - I-ALU (0010011): addi, andi, ori, slti
  - beq (1100011)
  - jal (1101111)
- sub is selected only for R-type with funct7[5]=1. addi is always add.
- Immediate by type, sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[19:12], instr[20], instr[30:21], 0}
- imm_extE is 0 for R-type.
- Control per class:
  - lw: reg_write=1, alu_src=1, result_src=01, add.
  - sw: mem_write=1, alu_src=1, add.
  - R-type: reg_write=1, ALU operation per funct3/funct7.
  - I-ALU: reg_write=1, alu_src=1, ALU operation per funct3.
  - beq: branch=1, sub.
  - jal: jump=1, reg_write=1, result_src=10.
- Bubble: instrD == 0 (the value inserted by fetch on flush/reset) decodes to all-zero control with illegalE=0.
- Illegal: any other unsupported opcode/funct combination.
  - Decodes to all-zero control with illegalE=1.
  - Data fields still register normally.
- Register file, 32×32:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write occurs on the rising edge when reg_writeW=1 and rdW≠0.
- Write-through bypass: if reg_writeW=1, rdW≠0 and rdW equals rs1D (or rs2D), the corresponding read returns resultW in that same cycle.
- ID/EX register has no stall input; the hazard unit stalls only F and D. When D is stalled, execute receives a bubble through flushE.

## Timing
- Latency: instrD presented in cycle n → E outputs valid after edge n+1.
- rs1D and rs2D are combinational (zero latency).
- Reset (rst=0 at an edge):
  - Every E output goes to 0.
  - All 32 registers are cleared to 0.
  - Any writeback in the same cycle is discarded.
- flushE=1 at an edge: every E output goes to 0, including illegalE, rdE and data. The register-file write in that cycle still occurs.
- Priority: rst > flushE > normal load.
- Simultaneous writeback and read of the same register: the new value reaches rd1E/rd2E on the same edge that commits the write.
- Reset released mid-stream: the first edge with rst=1 loads the decode of the current instrD.

## Test plan
- Reset: hold rst=0 for 2 cycles with instrD=0x00500093 → all E outputs 0. Then read x1..x31 → 0.
- addi x1,x0,5 (0x00500093):
  - E outputs: reg_writeE=1, alu_srcE=1, alu_controlE=000, imm_extE=5, rdE=1, illegalE=0.
  - Then reg_writeW=1, rdW=1, resultW=5 in the same cycle as add x2,x1,x1 (0x00108133) in D: rd1E=rd2E=5 (bypass), alu_controlE=000.
- Immediates:
  - sw x2,-4(x3) (0xFE21AE23) → imm_extE=0xFFFFFFFC, mem_writeE=1.
  - beq x0,x0,-8 (0xFE000CE3) → imm_extE=0xFFFFFFF8, branchE=1, alu_controlE=001.
  - jal x1,2048 (0x001000EF) → imm_extE=0x00000800, jumpE=1, result_srcE=10.
- x0 protection: writeback rdW=0, resultW=0xDEAD → a subsequent read of x0 returns 0.
- flushE=1 with lw x5,0(x1) in D → all E outputs 0 on the next edge. The concurrent writeback to x7 is still visible on a later read of x7.
- Illegal and bubble:
  - instrD=0xFFFFFFFF → illegalE=1 with all control 0.
  - instrD=0 → illegalE=0 with all control 0.
